alu_mul_pipe: RTL and testbench

ALU_MUL_PIPE -- requirements
Module: alu_mul_pipe

---
 rtl/alu_mul_pkg.sv | 22 ++
 rtl/alu_mul_stage.sv | 74 +++++++
 rtl/alu_mul_pipe.sv | 65 ++++++
 tb/tb_alu_mul_pipe.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mul_pkg.sv
// Shared defaults and payload layout for the pipelined unsigned product chain.
// Build option: ALU_MUL_PIPE_SAT_EN selects saturating stages (see alu_mul_stage).
package alu_mul_pkg;

    localparam int unsigned DEF_W  = 16;
    localparam int unsigned DEF_N  = 3;
    localparam int unsigned DEF_RW = 32;

    // Payload held by one stage at the default widths; stages re-declare it at their own widths.
    typedef struct packed {
        logic                        valid;
        logic [DEF_RW-1:0]           acc;
        logic                        ovf;
        logic [DEF_N*DEF_W-1:0]      ops;
    } stage_payload_t;

    // Bit offset of operand k inside the packed operand bus.
    function automatic int unsigned op_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/alu_mul_stage.sv
// One multiply stage: acc_out = low RW bits of acc_in * op(K), with overflow tracking and valid/hold.
// Build option: ALU_MUL_PIPE_SAT_EN forces acc to all ones when this stage overflows.
module alu_mul_stage
    import alu_mul_pkg::*;
#(
    parameter int unsigned W  = DEF_W,
    parameter int unsigned N  = DEF_N,
    parameter int unsigned RW = DEF_RW,
    parameter int unsigned K  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RW-1:0]     in_acc,
    input  logic              in_ovf,
    input  logic [N*W-1:0]    in_ops,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RW-1:0]     out_acc,
    output logic              out_ovf,
    output logic [N*W-1:0]    out_ops
);

    localparam int unsigned LSB = op_lsb(K, W);

    typedef struct packed {
        logic              valid;
        logic [RW-1:0]     acc;
        logic              ovf;
        logic [N*W-1:0]    ops;
    } payload_t;

    payload_t          q;
    logic [W-1:0]      op;
    logic [RW+W-1:0]   prod;
    logic              flag;
    logic [RW-1:0]     acc_next;

    assign op   = in_ops[LSB +: W];
    assign prod = {{W{1'b0}}, in_acc} * {{RW{1'b0}}, op};
    assign flag = |prod[RW+W-1:RW];

    always_comb begin
        acc_next = prod[RW-1:0];
`ifdef ALU_MUL_PIPE_SAT_EN
        if (flag) begin
            acc_next = '1;
        end
`endif
    end

    // Bubble-collapsing: load whenever empty or the successor takes our current contents.
    assign in_ready = !q.valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (in_ready) begin
            q.valid <= in_valid;
            if (in_valid) begin
                q.acc <= acc_next;
                q.ovf <= in_ovf | flag;
                q.ops <= in_ops;
            end
        end
    end

    assign out_valid = q.valid;
    assign out_acc   = q.acc;
    assign out_ovf   = q.ovf;
    assign out_ops   = q.ops;

endmodule

// File: rtl/alu_mul_pipe.sv
// Pipelined unsigned product of N operands, one multiply per registered stage, valid/ready on both sides.
// Build option: ALU_MUL_PIPE_SAT_EN enables per-stage saturation instead of modulo truncation.
module alu_mul_pipe
    import alu_mul_pkg::*;
#(
    parameter int unsigned W  = DEF_W,
    parameter int unsigned N  = DEF_N,
    parameter int unsigned RW = DEF_RW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*W-1:0]    in_ops,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RW-1:0]     out_data,
    output logic              out_ovf
);

    // Link k sits between stage k and stage k+1; link 0 is the input port.
    logic [N-1:0]      vld;
    logic [N-1:0]      rdy;
    logic [N-1:0]      ovf;
    logic [RW-1:0]     acc [0:N-1];
    logic [N*W-1:0]    ops [0:N-1];
    logic              ops_unused;

    assign vld[0]   = in_valid;
    assign acc[0]   = RW'(in_ops[W-1:0]);
    assign ovf[0]   = 1'b0;
    assign ops[0]   = in_ops;
    assign rdy[N-1] = out_ready;

    genvar k;
    for (k = 1; k < N; k++) begin : g_stage
        alu_mul_stage #(
            .W  (W),
            .N  (N),
            .RW (RW),
            .K  (k)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (vld[k-1]),
            .in_ready  (rdy[k-1]),
            .in_acc    (acc[k-1]),
            .in_ovf    (ovf[k-1]),
            .in_ops    (ops[k-1]),
            .out_valid (vld[k]),
            .out_ready (rdy[k]),
            .out_acc   (acc[k]),
            .out_ovf   (ovf[k]),
            .out_ops   (ops[k])
        );
    end

    // Stage 1 is already empty under reset, so gate the handshake explicitly.
    assign in_ready   = rdy[0] & ~reset;
    assign out_valid  = vld[N-1];
    assign out_data   = acc[N-1];
    assign out_ovf    = ovf[N-1];
    assign ops_unused = ^ops[N-1];

endmodule

// File: tb/tb_alu_mul_pipe.sv
// Self-checking bench for alu_mul_pipe (N=3 main instance, N=2 side instance) against a product model.
module tb_alu_mul_pipe;

    localparam int unsigned W  = 16;
    localparam int unsigned N  = 3;
    localparam int unsigned RW = 32;

    typedef struct {
        logic [RW-1:0] data;
        logic          ovf;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N*W-1:0]    in_ops = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [RW-1:0]     out_data;
    logic              out_ovf;

    logic              in_valid2 = 1'b0;
    logic              in_ready2;
    logic [2*W-1:0]    in_ops2 = '0;
    logic              out_valid2;
    logic              out_ready2 = 1'b1;
    logic [RW-1:0]     out_data2;
    logic              out_ovf2;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    exp_t        exp_q[$];

    always #5 clk = ~clk;

    alu_mul_pipe #(.W(W), .N(N), .RW(RW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_ops(in_ops),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
    );

    alu_mul_pipe #(.W(W), .N(2), .RW(RW)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .in_ops(in_ops2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_ovf(out_ovf2)
    );

    // Plain arithmetic: running product, overflow whenever it exceeds RW bits.
    function automatic exp_t model(input logic [N*W-1:0] ops, input int unsigned n);
        logic [63:0] acc;
        logic [63:0] full;
        logic [63:0] mask;
        exp_t        r;
        mask  = (64'd1 << RW) - 64'd1;
        acc   = 64'(ops[W-1:0]);
        r.ovf = 1'b0;
        for (int unsigned k = 1; k < n; k++) begin
            full = acc * 64'(ops[k*W +: W]);
            if (full > mask) begin
                r.ovf = 1'b1;
`ifdef ALU_MUL_PIPE_SAT_EN
                acc = mask;
`else
                acc = full & mask;
`endif
            end else begin
                acc = full;
            end
        end
        r.data = acc[RW-1:0];
        return r;
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 16'd1;
            2: return '1;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b need 0", in_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
        vectors++;
        if (out_data !== '0 || out_ovf !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_data: got %h/%b need 0/0", out_data, out_ovf);
        end
        vectors++;
        if (out_valid2 !== 1'b0 || in_ready2 !== 1'b0) begin
            miscompares++; $display("FAIL reset_n2: got valid %b ready %b need 0 0", out_valid2, in_ready2);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %b need 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [N*W-1:0] tbl [3];
        exp_t e;
        tbl[0] = {16'd7, 16'd5, 16'd3};
        tbl[1] = {16'd2, 16'hFFFF, 16'hFFFF};
        tbl[2] = {rand_op(), rand_op(), rand_op()};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e = model(tbl[i], N);
            in_valid = 1'b1;
            in_ops = tbl[i];
            @(posedge clk); #1;
            in_valid = 1'b0;
            vectors++;
            if (out_valid !== 1'b0) begin miscompares++; $display("FAIL directed%0d_early: got valid %b need 0", i, out_valid); end
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || out_data !== e.data || out_ovf !== e.ovf) begin
                miscompares++;
                $display("FAIL directed%0d: got v%b %h/%b need v1 %h/%b", i, out_valid, out_data, out_ovf, e.data, e.ovf);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_n2();
        exp_t e;
        logic [2*W-1:0] o;
        for (int i = 0; i < 4; i++) begin
            o = (i == 0) ? {16'h0010, 16'h1234} : {rand_op(), rand_op()};
            e = model({16'h0, o}, 2);
            in_valid2 = 1'b1;
            in_ops2 = o;
            @(posedge clk); #1;
            in_valid2 = 1'b0;
            vectors++;
            if (out_valid2 !== 1'b1 || out_data2 !== e.data || out_ovf2 !== e.ovf) begin
                miscompares++;
                $display("FAIL n2_case%0d: got v%b %h/%b need v1 %h/%b", i, out_valid2, out_data2, out_ovf2, e.data, e.ovf);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic exp_v;
        exp_q.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 10);
            in_ops = {16'd2, 16'(c + 2), 16'(c + 1)};
            #1;
            if (c < 10) begin
                vectors++;
                if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready c%0d: got %b need 1", c, in_ready); end
                exp_q.push_back(model(in_ops, N));
            end
            exp_v = (c >= 2 && c <= 11);
            vectors++;
            if (out_valid !== exp_v) begin miscompares++; $display("FAIL b2b_out_valid c%0d: got %b need %b", c, out_valid, exp_v); end
            if (out_valid === 1'b1 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (out_data !== e.data || out_ovf !== e.ovf) begin
                    miscompares++; $display("FAIL b2b_data c%0d: got %h/%b need %h/%b", c, out_data, out_ovf, e.data, e.ovf);
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stall();
        exp_t e;
        int unsigned accepts = 0;
        logic [RW-1:0] held_data = '0;
        logic held_ovf = 1'b0;
        logic held = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 5; c++) begin
            out_ready = 1'b0;
            in_valid = 1'b1;
            in_ops = {rand_op(), rand_op(), rand_op()};
            #1;
            if (c >= 2) begin
                vectors++;
                if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready c%0d: got %b need 0", c, in_ready); end
            end
            if (held) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== held_data || out_ovf !== held_ovf) begin
                    miscompares++; $display("FAIL stall_stable c%0d: got %h/%b need %h/%b", c, out_data, out_ovf, held_data, held_ovf);
                end
            end
            held = out_valid;
            held_data = out_data;
            held_ovf = out_ovf;
            if (in_ready === 1'b1) begin
                accepts++;
                exp_q.push_back(model(in_ops, N));
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (accepts != 2) begin miscompares++; $display("FAIL stall_accepts: got %0d need 2", accepts); end
        for (int c = 0; c < 30 && (exp_q.size() != 0 || c < 3); c++) begin
            out_ready = 1'b1;
            in_valid = (c < 3);
            in_ops = {rand_op(), rand_op(), rand_op()};
            #1;
            if (c < 3) begin
                vectors++;
                if (in_ready !== 1'b1) begin miscompares++; $display("FAIL full_in_ready c%0d: got %b need 1", c, in_ready); end
            end
            if (out_valid === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL stall_extra: got %h need no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_ovf !== e.ovf) begin
                        miscompares++; $display("FAIL stall_drain c%0d: got %h/%b need %h/%b", c, out_data, out_ovf, e.data, e.ovf);
                    end
                end
            end
            if (c < 3 && in_ready === 1'b1) exp_q.push_back(model(in_ops, N));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL stall_timeout: got %0d pending need 0", exp_q.size()); end
    endtask

    task automatic test_random();
        exp_t e;
        logic stalled = 1'b0;
        logic [RW-1:0] sd = '0;
        logic so = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 460; c++) begin
            in_valid = (c < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready = (c < 400) ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_ops = {rand_op(), rand_op(), rand_op()};
            #1;
            if (stalled) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== sd || out_ovf !== so) begin
                    miscompares++; $display("FAIL rand_stable c%0d: got %h/%b need %h/%b", c, out_data, out_ovf, sd, so);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL rand_extra c%0d: got %h need no output", c, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_ovf !== e.ovf) begin
                        miscompares++; $display("FAIL rand_data c%0d: got %h/%b need %h/%b", c, out_data, out_ovf, e.data, e.ovf);
                    end
                end
            end
            if (in_valid && in_ready === 1'b1) exp_q.push_back(model(in_ops, N));
            stalled = (out_valid === 1'b1) && !out_ready;
            sd = out_data;
            so = out_ovf;
            @(posedge clk); #1;
        end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL rand_timeout: got %0d pending need 0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight();
        exp_t e;
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            in_ops = {rand_op(), rand_op(), rand_op()};
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++; $display("FAIL midreset_flush: got valid %b ready %b need 0 0", out_valid, in_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_ghost c%0d: got %b need 0", c, out_valid); end
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_ops = {16'd4, 16'd3, 16'd2};
        e = model(in_ops, N);
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_early: got %b need 0", out_valid); end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== e.data || out_ovf !== e.ovf) begin
            miscompares++; $display("FAIL midreset_next: got v%b %h/%b need v1 %h/%b", out_valid, out_data, out_ovf, e.data, e.ovf);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout need completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_n2();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
